// File: rtl/fetch_unit_pkg.sv
// Shared opcodes, constants and types for the instruction fetch front end.
// The queue entry layout is also what decode sees on instr/currPC/new_addr.
package fetch_unit_pkg;

    localparam logic [4:0]  OP_HALT   = 5'b00000;
    localparam logic [4:0]  OP_NOP    = 5'b00001;
    localparam logic [15:0] NOP_INSTR = {OP_NOP, 11'b0};

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_DROP,
        ST_HALTED
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_next;
    } fq_entry_t;

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:11] == OP_HALT;
    endfunction

endpackage

// File: rtl/cla16b.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate
// feeding the carry into each following group.
module cla16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;

    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        c[0] = cin;
        for (int i = 0; i < 16; i++) begin
            // Last bit of each group takes the lookahead carry, not the ripple.
            if ((i % 4) == 3)
                c[i+1] = gg[i/4] | (gp[i/4] & c[i-3]);
            else
                c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum  = p ^ c[15:0];
        cout = c[16];
    end

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction queue between memory responses and decode.
// Flush wins over push and pop; count_nxt lets the fetcher gate issue a cycle early.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  fq_entry_t        push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt,
    output fq_entry_t        head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fq_entry_t        mem_q [DEPTH];
    fq_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)
                count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop)
                count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count     = count_q;
    assign count_nxt = count_d;
    assign head      = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Pipeline front end: sequential PC generation, one-outstanding memory fetch,
// instruction queue toward decode, redirect flush and HALT stop.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_REQ    | request fetch_pc when queue has room; accept moves to WAIT
// ST_WAIT   | one request in flight; response is pushed into the queue
// ST_DROP   | in-flight request was killed; swallow its response
// ST_HALTED | HALT fetched; no more requests until a redirect
module fetch_unit #(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_valid,
    input  logic [15:0] mem_rdata,
    output logic        fd_valid,
    input  logic        fd_ready,
    output logic [15:0] instr,
    output logic [15:0] currPC,
    output logic [15:0] new_addr,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        err
);

    import fetch_unit_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [15:0]      fetch_pc_q, fetch_pc_d;
    logic             mem_req_q, mem_req_d;
    logic             err_q, err_d;
    logic [15:0]      pc_plus2;
    logic             pc_carry_unused;
    logic             handshake;
    logic             head_valid;
    logic             q_push;
    logic             q_pop;
    logic             q_flush;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] q_count_nxt;
    fq_entry_t        q_head;
    fq_entry_t        q_push_data;

    cla16b u_pc_add (
        .a    (fetch_pc_q),
        .b    (16'h0002),
        .cin  (1'b0),
        .sum  (pc_plus2),
        .cout (pc_carry_unused)
    );

    assign handshake   = mem_req_q && mem_ready;
    assign head_valid  = (q_count != '0);
    assign q_flush     = redirect;
    assign q_pop       = head_valid && fd_ready && !q_flush;
    assign q_push_data = '{instr: mem_rdata, pc: fetch_pc_q, pc_next: pc_plus2};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        q_push     = 1'b0;
        err_d      = 1'b0;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[15:1], 1'b0};
            err_d      = redirect_pc[0];
            // A response is still owed only if a request was accepted and not yet answered.
            unique case (state_q)
                ST_REQ:           state_d = handshake ? ST_DROP : ST_REQ;
                ST_WAIT, ST_DROP: state_d = mem_valid ? ST_REQ : ST_DROP;
                ST_HALTED:        state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (handshake)
                        state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_valid) begin
                        q_push     = 1'b1;
                        fetch_pc_d = pc_plus2;
                        state_d    = is_halt(mem_rdata) ? ST_HALTED : ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (mem_valid)
                        state_d = ST_REQ;
                end
                ST_HALTED: state_d = ST_HALTED;
            endcase
        end
    end

    // In REQ nothing is in flight, so next occupancy alone bounds the issue.
    assign mem_req_d = (state_d == ST_REQ) && (q_count_nxt < CNT_W'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            err_q      <= err_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_b     (rst),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (q_flush),
        .count     (q_count),
        .count_nxt (q_count_nxt),
        .head      (q_head)
    );

    assign mem_req  = mem_req_q;
    assign mem_addr = fetch_pc_q;
    assign fd_valid = head_valid;
    assign instr    = head_valid ? q_head.instr   : NOP_INSTR;
    assign currPC   = head_valid ? q_head.pc      : 16'h0000;
    assign new_addr = head_valid ? q_head.pc_next : 16'h0000;
    assign err      = err_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front end of the five-stage pipeline. Generates sequential fetch PCs and runs a one-outstanding request/response handshake with instruction memory.
- Buffers returned instructions in a small queue and presents them to the decode stage as instr, currPC and new_addr (PC+2) under a valid/ready handshake.
- Accepts redirects (taken branch or jump target) back from decode and flushes wrong-path work.
- Stops prefetching after a HALT instruction.

Parameters:
- DEPTH, 2, instruction queue entries (power of two, at least 2).
- RESET_PC, 16'h0000, fetch PC loaded on reset.
- NOP_INSTR, 16'h0800, value driven on instr when the queue is empty (opcode 00001).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_req  output  1  request valid to instruction memory.
- mem_addr  output  16  fetch address; stable while mem_req=1 and mem_ready=0.
- mem_ready  input  1  memory accepts the request this cycle.
- mem_valid  input  1  read data valid, one pulse per accepted request.
- mem_rdata  input  16  instruction word.
- fd_valid  output  1  queue head is valid toward decode.
- fd_ready  input  1  decode consumes the head this cycle (low means decode is stalled).
- instr  output  16  head instruction, or NOP_INSTR when the queue is empty.
- currPC  output  16  PC of the head instruction.
- new_addr  output  16  currPC+2.
- redirect  input  1  decode resolved a taken branch or jump.
- redirect_pc  input  16  target PC.
- err  output  1  one-cycle pulse when redirect_pc[0]=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - Fetch PC is RESET_PC; queue is empty; state is REQ.
  - mem_req=0, fd_valid=0, instr=NOP_INSTR, currPC=0, new_addr=0, err=0.
- States:
  - REQ: mem_req=1 when queue count plus in-flight count is less than DEPTH; mem_addr=fetch_pc. Handshake with mem_ready=1 moves to WAIT.
  - WAIT: on mem_valid, push {mem_rdata, fetch_pc, fetch_pc+2} into the queue and advance fetch_pc by 2. Next state is HALTED if mem_rdata[15:11]=00000, otherwise REQ.
  - DROP: the request in flight was killed by a redirect. The next mem_valid is discarded, then the state moves to REQ. mem_req=0 in this state.
  - HALTED: mem_req=0. The queue still drains to decode.
- Ordering: at most one request outstanding. A request is issued at the earliest on the cycle after the previous mem_valid (REQ follows WAIT).
- Redirect (highest priority, any state):
  - Queue is flushed, fetch_pc is loaded with {redirect_pc[15:1],1'b0}, and err=redirect_pc[0] for one cycle.
  - In WAIT without mem_valid in the same cycle, go to DROP.
  - In WAIT with mem_valid in the same cycle, discard the data and go to REQ.
  - In REQ (including a mem_ready=1 cycle), the accepted request is treated as killed and the state goes to DROP.
  - In HALTED or DROP, the state goes to REQ, or stays in DROP if a response is still owed.
- Decode handshake: a pop occurs when fd_valid and fd_ready are both 1.
  - Push and pop may happen in the same cycle.
  - A flush overrides a pop in the same cycle.
  - Outputs are registered from the queue head; no combinational path from mem_rdata to instr.
- Arithmetic: PC+2 is 16-bit modulo, so 16'hFFFE wraps to 16'h0000. Queue pointers wrap modulo DEPTH. Occupancy is a counter from 0 to DEPTH.
- Boundaries:
  - The queue can never overflow, because issue is gated by count plus in-flight.
  - mem_valid arriving outside WAIT or DROP is ignored.
  - fd_ready=1 on an empty queue has no effect.
  - Reset asserted mid-transaction abandons the transaction; memory is reset on the same rst.

Decomposition:
- Shared package (with the decode and control constants):
  - OP_HALT=5'b00000 and OP_NOP=5'b00001.
  - NOP_INSTR.
  - Fetch-state encoding: REQ, WAIT, DROP, HALTED.
- One sub-module, fetch_queue: a circular FIFO holding DEPTH entries of 48 bits (instr, pc, pc+2), with push, pop, flush, count, head.
- PC+2 uses the existing cla16b adder.

Test Plan:
- Reset, fd_ready=1, zero-wait memory returning 16'h4000 at every address -> mem_addr sequence 0000, 0002, 0004; fd_valid rises; currPC/new_addr read 0000/0002, then 0002/0004.
- fd_ready=0 held -> exactly DEPTH=2 requests issued, then mem_req=0. Raising fd_ready -> heads 0000 then 0002 popped, and fetching resumes at 0004.
- Redirect to 16'h0100 while in WAIT, then mem_valid two cycles later -> stale word dropped; next mem_addr=0100; fd_valid=0 until the 0100 word arrives.
- Redirect and mem_valid in the same cycle -> data discarded, state goes directly to REQ with mem_addr=0100.
- Memory returns 16'h0000 at 0006 -> state HALTED, no further mem_req, HALT delivered to decode. A later redirect to 0020 -> fetch resumes at 0020.
- Redirect to 16'h0103 -> err pulses for one cycle; next mem_addr=0102. Also: fetch_pc=FFFE -> next address 0000.
